// File: rtl/faxi_pkg.sv
// Shared types and constants for the FAXI burst address generator.
package faxi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_RSVD  = 2'b10,
        BURST_WRAP  = 2'b11
    } burst_e;

    localparam int unsigned BOUNDARY_BITS  = 12;
    localparam int unsigned BOUNDARY_BYTES = 1 << BOUNDARY_BITS;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

endpackage

// File: rtl/faxi_burst_addr_gen_if.sv
// Request and beat channels of the burst address generator, bundled for benches and wrappers.
interface faxi_burst_addr_gen_if #(
    parameter int unsigned AW  = 32,
    parameter int unsigned DW  = 32,
    parameter int unsigned IDW = 4
);
    logic              req_valid;
    logic              req_ready;
    logic [AW-1:0]     req_addr;
    logic [7:0]        req_len;
    logic [2:0]        req_size;
    logic [1:0]        req_burst;
    logic [IDW-1:0]    req_id;
    logic              beat_valid;
    logic              beat_ready;
    logic [AW-1:0]     beat_addr;
    logic [DW/8-1:0]   beat_strb;
    logic [7:0]        beat_idx;
    logic              beat_last;
    logic [IDW-1:0]    beat_id;
    logic              err;

    modport master (
        output req_valid, req_addr, req_len, req_size, req_burst, req_id, beat_ready,
        input  req_ready, beat_valid, beat_addr, beat_strb, beat_idx, beat_last, beat_id, err
    );

    modport slave (
        input  req_valid, req_addr, req_len, req_size, req_burst, req_id, beat_ready,
        output req_ready, beat_valid, beat_addr, beat_strb, beat_idx, beat_last, beat_id, err
    );
endinterface

// File: rtl/faxi_next_addr.sv
// Combinational next-beat address and byte-lane strobe for FIXED/INCR/WRAP bursts.
module faxi_next_addr
    import faxi_pkg::*;
#(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic [AW-1:0]   i_addr,
    input  logic [2:0]      i_size,
    input  logic [7:0]      i_len,
    input  logic [1:0]      i_burst,
    input  logic            i_advance,
    output logic [AW-1:0]   o_addr,
    output logic [DW/8-1:0] o_strb
);
    localparam int unsigned NB = DW / 8;

    logic [AW-1:0] size_bytes;
    logic [AW-1:0] aligned;
    logic [AW-1:0] wrap_mask;
    logic [AW-1:0] nxt;
    logic [AW-1:0] lo;
    logic [AW-1:0] hi;

    // Address step for the selected burst type
    always_comb begin
        size_bytes = AW'(1) << i_size;
        aligned    = i_addr & ~(size_bytes - AW'(1));
        wrap_mask  = ((AW'(i_len) + AW'(1)) << i_size) - AW'(1);
        case (burst_e'(i_burst))
            BURST_INCR: nxt = aligned + size_bytes;
            BURST_WRAP: nxt = (i_addr & ~wrap_mask) | ((i_addr + size_bytes) & wrap_mask);
            default:    nxt = i_addr;
        endcase
        o_addr = i_advance ? nxt : i_addr;
    end

    // Lanes from the byte address up to the end of the size-aligned container
    always_comb begin
        lo = o_addr & AW'(NB - 1);
        hi = ((o_addr & ~(size_bytes - AW'(1))) & AW'(NB - 1)) + size_bytes - AW'(1);
        for (int i = 0; i < int'(NB); i++) begin
            o_strb[i] = (AW'(i) >= lo) && (AW'(i) <= hi);
        end
    end

endmodule

// File: rtl/faxi_burst_addr_gen.sv
// Accepts AXI-style burst requests and emits one address/strobe beat per handshake.
module faxi_burst_addr_gen
    import faxi_pkg::*;
#(
    parameter int unsigned AW  = 32,
    parameter int unsigned DW  = 32,
    parameter int unsigned IDW = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [AW-1:0]     i_req_addr,
    input  logic [7:0]        i_req_len,
    input  logic [2:0]        i_req_size,
    input  logic [1:0]        i_req_burst,
    input  logic [IDW-1:0]    i_req_id,
    output logic              o_beat_valid,
    input  logic              i_beat_ready,
    output logic [AW-1:0]     o_beat_addr,
    output logic [DW/8-1:0]   o_beat_strb,
    output logic [7:0]        o_beat_idx,
    output logic              o_beat_last,
    output logic [IDW-1:0]    o_beat_id,
    output logic              o_err
);
    localparam int unsigned NB    = DW / 8;
    localparam int unsigned MAXSZ = $clog2(NB);

    state_e            state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              beat_valid_q, beat_valid_d;
    logic [AW-1:0]     beat_addr_q, beat_addr_d;
    logic [NB-1:0]     beat_strb_q, beat_strb_d;
    logic [7:0]        beat_idx_q, beat_idx_d;
    logic              beat_last_q, beat_last_d;
    logic [IDW-1:0]    beat_id_q, beat_id_d;
    logic              err_q, err_d;
    logic [7:0]        len_q, len_d;
    logic [2:0]        size_q, size_d;
    logic [1:0]        burst_q, burst_d;

    logic              idle;
    logic [AW-1:0]     na_addr_in;
    logic [2:0]        na_size;
    logic [7:0]        na_len;
    logic [1:0]        na_burst;
    logic [AW-1:0]     na_addr;
    logic [NB-1:0]     na_strb;

    logic [31:0]       req_bytes;
    logic [31:0]       req_low;
    logic [31:0]       req_span_end;
    logic              illegal;

    // In IDLE the helper yields the strobe of the incoming start address; in BURST the next beat
    assign idle       = (state_q == ST_IDLE);
    assign na_addr_in = idle ? i_req_addr  : beat_addr_q;
    assign na_size    = idle ? i_req_size  : size_q;
    assign na_len     = idle ? i_req_len   : len_q;
    assign na_burst   = idle ? i_req_burst : burst_q;

    faxi_next_addr #(.AW(AW), .DW(DW)) u_next_addr (
        .i_addr    (na_addr_in),
        .i_size    (na_size),
        .i_len     (na_len),
        .i_burst   (na_burst),
        .i_advance (!idle),
        .o_addr    (na_addr),
        .o_strb    (na_strb)
    );

    // Request legality, including the 4 KB crossing test on the size-aligned INCR range
    always_comb begin
        req_bytes    = 32'd1 << i_req_size;
        req_low      = 32'(i_req_addr[BOUNDARY_BITS-1:0]) & ~(req_bytes - 32'd1);
        req_span_end = req_low + ((32'(i_req_len) + 32'd1) << i_req_size);
        illegal      = 1'b0;
        if (i_req_size > 3'(MAXSZ)) illegal = 1'b1;
        case (burst_e'(i_req_burst))
            BURST_RSVD:  illegal = 1'b1;
            BURST_FIXED: if (i_req_len > 8'd15) illegal = 1'b1;
            BURST_INCR:  if (req_span_end > 32'(BOUNDARY_BYTES)) illegal = 1'b1;
            BURST_WRAP: begin
                if (!(i_req_len == 8'd1 || i_req_len == 8'd3 ||
                      i_req_len == 8'd7 || i_req_len == 8'd15)) illegal = 1'b1;
                if ((32'(i_req_addr[BOUNDARY_BITS-1:0]) & (req_bytes - 32'd1)) != 32'd0)
                    illegal = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        beat_valid_d = beat_valid_q;
        beat_addr_d  = beat_addr_q;
        beat_strb_d  = beat_strb_q;
        beat_idx_d   = beat_idx_q;
        beat_last_d  = beat_last_q;
        beat_id_d    = beat_id_q;
        len_d        = len_q;
        size_d       = size_q;
        burst_d      = burst_q;
        err_d        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_req_valid && req_ready_q) begin
                    if (illegal) begin
                        err_d = 1'b1;
                    end else begin
                        state_d      = ST_BURST;
                        beat_valid_d = 1'b1;
                        beat_addr_d  = i_req_addr;
                        beat_strb_d  = na_strb;
                        beat_idx_d   = 8'd0;
                        beat_last_d  = (i_req_len == 8'd0);
                        beat_id_d    = i_req_id;
                        len_d        = i_req_len;
                        size_d       = i_req_size;
                        burst_d      = i_req_burst;
                    end
                end
            end
            ST_BURST: begin
                if (i_beat_ready) begin
                    if (beat_last_q) begin
                        state_d      = ST_IDLE;
                        beat_valid_d = 1'b0;
                    end else begin
                        beat_addr_d = na_addr;
                        beat_strb_d = na_strb;
                        beat_idx_d  = beat_idx_q + 8'd1;
                        beat_last_d = ((beat_idx_q + 8'd1) == len_q);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        req_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= 1'b0;
            beat_valid_q <= 1'b0;
            beat_addr_q  <= '0;
            beat_strb_q  <= '0;
            beat_idx_q   <= '0;
            beat_last_q  <= 1'b0;
            beat_id_q    <= '0;
            err_q        <= 1'b0;
            len_q        <= '0;
            size_q       <= '0;
            burst_q      <= '0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            beat_valid_q <= beat_valid_d;
            beat_addr_q  <= beat_addr_d;
            beat_strb_q  <= beat_strb_d;
            beat_idx_q   <= beat_idx_d;
            beat_last_q  <= beat_last_d;
            beat_id_q    <= beat_id_d;
            err_q        <= err_d;
            len_q        <= len_d;
            size_q       <= size_d;
            burst_q      <= burst_d;
        end
    end

    assign o_req_ready  = req_ready_q;
    assign o_beat_valid = beat_valid_q;
    assign o_beat_addr  = beat_addr_q;
    assign o_beat_strb  = beat_strb_q;
    assign o_beat_idx   = beat_idx_q;
    assign o_beat_last  = beat_last_q;
    assign o_beat_id    = beat_id_q;
    assign o_err        = err_q;

endmodule

// File: doc/faxi_burst_addr_gen.md
FAXI_BURST_ADDR_GEN -- requirements
Module: faxi_burst_addr_gen

Interface
REQ-001 SHALL have parameter AW, default 32: address width in bits.
REQ-002 SHALL have parameter DW, default 32: data bus width in bits (power of two, 8..1024); NB = DW/8 byte lanes; MAXSZ = log2(NB).
REQ-003 SHALL have parameter IDW, default 4: transaction ID width.
REQ-004 Clocking SHALL be one clock, i_clk; reset SHALL be i_rst_n, asynchronous, active-low.
REQ-005 SHALL have ports, in order:
- i_clk, in, 1: clock.
- i_rst_n, in, 1: async active-low reset.
- i_req_valid, in, 1: request valid.
- o_req_ready, out, 1: request ready.
- i_req_addr, in, AW: burst start address.
- i_req_len, in, 8: beats minus 1.
- i_req_size, in, 3: log2 of bytes per beat.
- i_req_burst, in, 2: burst type.
- i_req_id, in, IDW: transaction ID.
- o_beat_valid, out, 1: beat valid.
- i_beat_ready, in, 1: beat accepted.
- o_beat_addr, out, AW: beat address.
- o_beat_strb, out, NB: active byte lanes.
- o_beat_idx, out, 8: beat number, 0..len.
- o_beat_last, out, 1: final beat.
- o_beat_id, out, IDW: ID of the current burst.
- o_err, out, 1: one-cycle illegal-request pulse.

Function
REQ-006 Burst encodings SHALL be FIXED=2'b00, INCR=2'b01, WRAP=2'b11; 2'b10 is reserved.
REQ-007 The FSM SHALL have two states: IDLE and BURST. o_req_ready SHALL equal 1 exactly when the FSM is in IDLE.
REQ-008 A request handshake (valid&ready) SHALL register addr, len, size, burst and id; o_beat_valid SHALL rise on the next cycle with o_beat_addr = i_req_addr and o_beat_idx = 0.
REQ-009 A request SHALL be illegal if any of the following holds:
- size > MAXSZ;
- burst is reserved;
- burst is WRAP and len is not in {1,3,7,15};
- burst is WRAP and the start address is not size-aligned;
- burst is FIXED and len > 15;
- burst is INCR and the range from the size-aligned start address for (len+1)<<size bytes crosses a 4 KB boundary.
REQ-010 An illegal request SHALL be accepted, SHALL pulse o_err high for exactly one cycle after acceptance, SHALL produce no beats, and the FSM SHALL remain in IDLE.
REQ-011 A beat handshake (o_beat_valid&i_beat_ready) SHALL advance the beat:
- o_beat_idx increments;
- FIXED: the address is unchanged;
- INCR: next = size-aligned(addr) + 2^size;
- WRAP: next = (addr with low log2((len+1)<<size) bits replaced by those bits of (addr + 2^size)).
REQ-012 o_beat_last SHALL be 1 exactly when o_beat_idx == len.
REQ-013 A handshake on the last beat SHALL return the FSM to IDLE: o_beat_valid goes 0 and o_req_ready goes 1 in the next cycle. Back-to-back bursts therefore have exactly one idle cycle between them.
REQ-014 While o_beat_valid=1 and i_beat_ready=0, all o_beat_* outputs SHALL hold stable.
REQ-015 o_beat_strb SHALL set lanes lo..hi, where lo = addr mod NB and hi = (size-aligned(addr) mod NB) + 2^size - 1. An unaligned first INCR/FIXED beat is therefore partial.
REQ-016 All address arithmetic SHALL be AW bits wide. Increment arithmetic SHALL saturate nothing; the 4 KB check guarantees no carry beyond bit 11 for legal INCR bursts.

Reset
REQ-017 Assertion of i_rst_n=0 SHALL immediately force:
- FSM to IDLE;
- o_req_ready=0, o_beat_valid=0, o_beat_last=0, o_err=0;
- o_beat_addr, o_beat_strb, o_beat_idx and o_beat_id to 0.
REQ-018 o_req_ready SHALL go to 1 on the first i_clk edge after deassertion. A burst in flight at reset SHALL be discarded, with no further beats.

Structure
REQ-019 Package faxi_pkg SHALL hold the burst encodings, the 4 KB boundary constant (12 bits), and the state enumeration.
REQ-020 Next-address and strobe computation SHALL be one combinational sub-module, faxi_next_addr (params AW, DW), instantiated once.

Verification (DW=32)
REQ-021 INCR, addr 0x1002, size 2, len 3 -> addresses 0x1002, 0x1004, 0x1008, 0x100C; strb 4'b1100, 4'b1111, 4'b1111, 4'b1111; o_beat_last only on idx 3.
REQ-022 WRAP, addr 0x38, size 2, len 3 -> addresses 0x38, 0x3C, 0x30, 0x34, all strb 4'b1111.
REQ-023 FIXED, addr 0x22, size 1, len 2 -> address 0x22 on three beats, strb 4'b1100 each.
REQ-024 INCR, addr 0xFF8, size 2, len 3 -> o_err one-cycle pulse, no o_beat_valid, o_req_ready=1 on the following cycle.
REQ-025 Backpressure: i_beat_ready=0 for 3 cycles at idx 1 of the REQ-021 burst -> outputs held stable, sequence completes unchanged.
REQ-026 Reset mid-burst at idx 2 -> o_beat_valid=0 immediately; o_req_ready=1 on the first edge after release; the next request starts at idx 0.
